// File: rtl/instruction_memory.sv
// Byte-addressed instruction ROM/RAM: 32-bit little-endian fetch from any byte address, boot image mem[k]=k.
// Latency: read combinational (0 cycles), byte write visible after the edge; no backpressure, always accepts.
module instruction_memory #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [61:0] Inst_Address,
    output logic [31:0] Instruction,
    input  logic        Wr_En,
    input  logic [61:0] Wr_Address,
    input  logic [7:0]  Wr_Data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [62:0] DEPTH_EXT = 63'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    logic          wr_hit;
    logic [AW-1:0] wr_idx;

    assign wr_hit = Wr_En && ({1'b0, Wr_Address} < DEPTH_EXT);
    assign wr_idx = Wr_Address[AW-1:0];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
        end
        if (wr_hit) begin
            mem_d[wr_idx] = Wr_Data;
        end
    end

    // Reset reloads the boot image and wins over any write on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= 8'(k);
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    // Sums use 63 bits so a carry past 2^62-1 lands in bit 62 and reads as out of range.
    logic [62:0] byte_addr [4];
    logic [7:0]  byte_val  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_addr[i] = {1'b0, Inst_Address} + 63'(i);
            byte_val[i]  = 8'h00;
            if (byte_addr[i] < DEPTH_EXT) begin
                byte_val[i] = mem_q[byte_addr[i][AW-1:0]];
            end
        end
    end

    assign Instruction = {byte_val[3], byte_val[2], byte_val[1], byte_val[0]};

endmodule

// File: tb/tb_instruction_memory.sv
// Directed plan checks plus randomized write/reset/read traffic against a byte-array reference model.
module tb_instruction_memory;

    localparam int DEPTH = 64;
    localparam logic [61:0] TOP = 62'h3FFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [61:0] Inst_Address;
    logic [31:0] Instruction;
    logic        Wr_En;
    logic [61:0] Wr_Address;
    logic [7:0]  Wr_Data;

    int tests;
    int fails;
    byte unsigned mdl [DEPTH];

    instruction_memory #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .Inst_Address (Inst_Address),
        .Instruction  (Instruction),
        .Wr_En        (Wr_En),
        .Wr_Address   (Wr_Address),
        .Wr_Data      (Wr_Data)
    );

    function automatic void mdl_boot();
        for (int k = 0; k < DEPTH; k++) mdl[k] = 8'(k);
    endfunction

    function automatic logic [31:0] ref_word(input logic [61:0] a);
        logic [31:0] w;
        longint unsigned base;
        longint unsigned x;
        w = 32'h0;
        base = longint'(a);
        for (int i = 0; i < 4; i++) begin
            x = base + longint'(i);
            if (x < longint'(DEPTH) && x <= longint'(TOP)) w = w | (32'(mdl[x]) << (8 * i));
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [61:0] a, input logic [31:0] exp);
        Inst_Address = a;
        #1;
        check(tag, Instruction, exp);
    endtask

    // One rising edge; the model applies the write only if reset is high.
    task automatic tick();
        #4 clk = 1'b1;
        if (reset && Wr_En && Wr_Address < 62'(DEPTH)) mdl[Wr_Address] = Wr_Data;
        #5 clk = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [61:0] a, input logic [7:0] d);
        Wr_En = 1'b1; Wr_Address = a; Wr_Data = d;
        tick();
        Wr_En = 1'b0;
    endtask

    initial begin
        logic [61:0] a;
        tests = 0; fails = 0;
        clk = 1'b0; Wr_En = 1'b0; Wr_Address = '0; Wr_Data = '0; Inst_Address = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        mdl_boot();
        #1;

        // Reads with reset held and no clock.
        read_chk("rst_a0",  62'd0,  32'h03020100);
        read_chk("rst_a2",  62'd2,  32'h05040302);
        read_chk("rst_a3",  62'd3,  32'h06050403);
        read_chk("rst_a14", 62'd14, 32'h11100F0E);
        read_chk("rst_a12", 62'd12, 32'h0F0E0D0C);
        read_chk("hi_a60",  62'd60, 32'h3F3E3D3C);
        read_chk("hi_a62",  62'd62, 32'h00003F3E);
        read_chk("hi_a64",  62'd64, 32'h00000000);
        read_chk("hi_wrap", TOP - 62'd1, 32'h00000000);
        read_chk("hi_top",  TOP, 32'h00000000);

        #3 reset = 1'b1;
        #1;
        wr(62'd4, 8'h13);
        wr(62'd5, 8'h00);
        wr(62'd6, 8'h50);
        wr(62'd7, 8'h00);
        read_chk("wr_a4", 62'd4, 32'h00500013);
        read_chk("wr_a3", 62'd3, 32'h50001303);
        wr(62'd100, 8'hEE);
        read_chk("oor_a4", 62'd4, 32'h00500013);
        read_chk("oor_a60", 62'd60, 32'h3F3E3D3C);

        // Async reset between edges, then writes attempted while held.
        Inst_Address = 62'd4;
        #2 reset = 1'b0;
        mdl_boot();
        #1 check("async_rst_a4", Instruction, 32'h07060504);
        wr(62'd5, 8'h77);
        read_chk("rst_wr_a4", 62'd4, 32'h07060504);
        wr(62'd0, 8'hAA);
        read_chk("rst_wr_a0", 62'd0, 32'h03020100);
        reset = 1'b1;
        #1;
        wr(62'd0, 8'hAA);
        read_chk("wr_a0", 62'd0, 32'h030201AA);

        // Read-during-write: old before the edge, new after.
        Inst_Address = 62'd8;
        Wr_En = 1'b1; Wr_Address = 62'd9; Wr_Data = 8'h5A;
        #1 check("rdw_before", Instruction, 32'h0B0A0908);
        tick();
        Wr_En = 1'b0;
        check("rdw_after", Instruction, 32'h0B0A5A08);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    #2 reset = 1'b0;
                    mdl_boot();
                    if ($urandom_range(0, 1) == 1) begin
                        Wr_En = 1'b1; Wr_Address = 62'($urandom_range(0, DEPTH - 1));
                        Wr_Data = 8'($urandom);
                        tick();
                        Wr_En = 1'b0;
                    end
                    #1 reset = 1'b1;
                    #1;
                end
                1, 2: wr(62'($urandom_range(DEPTH, 300)), 8'($urandom));
                3: begin
                    Wr_En = 1'b0; Wr_Address = 62'($urandom_range(0, DEPTH - 1));
                    Wr_Data = 8'($urandom);
                    tick();
                end
                default: wr(62'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            endcase
            case ($urandom_range(0, 3))
                0: a = TOP - 62'($urandom_range(0, 5));
                1: a = 62'($urandom_range(DEPTH - 5, DEPTH + 2));
                default: a = 62'($urandom_range(0, DEPTH - 1));
            endcase
            read_chk("rand_rd", a, ref_word(a));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
